// File: rtl/pipeline_sequencer.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// wrong-path squash on jumps/taken branches, and the syscall drain/handshake FSM.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_instr,
  input  logic               id_syscall,
  input  logic               id_jump,
  input  logic               id_branch_taken,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rt,
  input  logic               sys_ack,
  input  logic               sys_exit,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               sys_req,
  output logic               halted,
  output logic [2:0]         state,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_DRAIN   = 3'd1,
    S_SYS     = 3'd2,
    S_RELEASE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  state_e             state_q;
  logic [3:0]         drain_q;
  logic [STALL_W-1:0] stall_q;

  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt;
  logic       uses_rt;
  logic       lu;
  logic       unused_ok;

  assign opcode    = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign unused_ok = ^id_instr[15:0];

  // R-type, BEQ, BNE and SW read rt as a source; everything else treats rt as a destination.
  always_comb begin
    uses_rt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  assign lu = ex_mem_read & (ex_rt != 5'd0) &
              ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    sys_req     = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          if (!lu && !id_syscall) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = id_jump | id_branch_taken;
            idex_bubble = 1'b0;
          end
        end
        S_SYS:     sys_req = 1'b1;
        S_RELEASE: begin
          // The syscall still sits in IF/ID; fetch past it and squash it.
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
        S_HALT:    halted = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      drain_q <= 4'd0;
      stall_q <= '0;
    end else begin
      if (!pc_write && (state_q != S_HALT) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      case (state_q)
        S_RUN: begin
          if (!lu && id_syscall) begin
            state_q <= S_DRAIN;
            drain_q <= 4'd0;
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
            state_q <= S_SYS;
            drain_q <= 4'd0;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        S_SYS: begin
          if (sys_ack) state_q <= sys_exit ? S_HALT : S_RELEASE;
        end
        S_RELEASE: state_q <= S_RUN;
        S_HALT:    state_q <= S_HALT;
        default:   state_q <= S_RUN;
      endcase
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the decode-stage control unit and drives the PC and pipeline-register enables, flushes and bubbles. It detects load-use hazards, squashes the wrong-path fetch on jumps and taken branches, and runs a syscall drain/handshake FSM. The FSM empties the pipeline before handing off to the syscall service and resumes or halts afterwards.

Parameters:
DRAIN_CYCLES, 3, cycles of bubbles inserted after a syscall reaches ID, so EX/MEM/WB retire before sys_req (range 1..15)
STALL_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
id_instr  input  32  instruction in IF/ID
id_syscall  input  1  syscall_control decoded from id_instr
id_jump  input  1  J/JAL/JR in ID
id_branch_taken  input  1  BEQ/BNE in ID resolved taken
ex_mem_read  input  1  MemRead of the instruction in ID/EX
ex_rt  input  5  destination rt of the instruction in ID/EX
sys_ack  input  1  syscall service done (single-cycle pulse or level)
sys_exit  input  1  qualifies sys_ack: program exit requested
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads a NOP next edge
idex_bubble  output  1  ID/EX loads zero control (EX_D/MEM_D/WB_D = 0)
sys_req  output  1  request to syscall service, Moore
halted  output  1  pipeline permanently stopped
state  output  3  FSM state: RUN=0, DRAIN=1, SYS=2, RELEASE=3, HALT=4
stall_count  output  STALL_W  cycles with pc_write=0, saturating

Behaviour:
- Reset (rst=1 at an edge): state=RUN, drain counter=0, stall_count=0. While rst is high, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, sys_req=0, halted=0. Reset mid-DRAIN/SYS/HALT returns to RUN with no sys_req.
- Load-use hazard is combinational: lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_instr[25:21]) | (uses_rt & ex_rt == id_instr[20:16])).
  - uses_rt = 1 when opcode id_instr[31:26] is 0x00, 0x04, 0x05 or 0x2B.
- RUN outputs (combinational), in priority order:
  - If lu: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Jump, branch and syscall are ignored this cycle.
  - Else if id_syscall: enter DRAIN next edge; this cycle pc_write=0, ifid_write=0, idex_bubble=1.
  - Else if id_jump | id_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0. No delay slot.
  - Else: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- DRAIN: pc_write=0, ifid_write=0, idex_bubble=1. The counter increments each cycle. After exactly DRAIN_CYCLES cycles in DRAIN, go to SYS and clear the counter.
- SYS: same stall outputs, sys_req=1. Wait indefinitely.
  - sys_ack=1 & sys_exit=0 -> RELEASE.
  - sys_ack=1 & sys_exit=1 -> HALT.
  - sys_ack is ignored in every other state.
- RELEASE (1 cycle): sys_req=0, pc_write=1, ifid_write=1, ifid_flush=1 (syscall consumed from IF/ID), idex_bubble=1. Then RUN.
- HALT: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. Leave only on rst.
- Hazard inputs are don't-care outside RUN.
- stall_count increments on every non-reset cycle with pc_write=0 and state != HALT. It holds at all-ones.
- Syscall latency: sys_req first rises 1+DRAIN_CYCLES cycles after the cycle id_syscall is seen with lu=0.

Test Plan:
- lu stall: ex_mem_read=1, ex_rt=8, id_instr=ADD using rs=8 -> one cycle pc_write=0/ifid_write=0/idex_bubble=1; stall_count=1. Repeat with ex_rt=0 -> no stall.
- rt usage: ex_rt=9 matches rt of ORI (opcode 0x0D) -> no stall; same rt match on SW (0x2B) -> stall.
- Flush: id_jump=1, no hazard -> ifid_flush=1, pc_write=1 for one cycle. id_branch_taken=1 with lu=1 -> stall, ifid_flush=0.
- Syscall: id_syscall=1, DRAIN_CYCLES=3 -> state 0,1,1,1,2; sys_req high from cycle 4. sys_ack after 5 cycles -> one RELEASE cycle with ifid_flush=1/idex_bubble=1, then RUN. stall_count=9.
- Exit: in SYS, sys_ack=1 & sys_exit=1 -> HALT, halted=1, pc_write=0 for 20 cycles, stall_count frozen. rst -> RUN, halted=0, stall_count=0.
- Reset mid-SYS: rst during sys_req=1 -> sys_req=0 same cycle, state=RUN after edge. Stray sys_ack in RUN -> no effect.
